imem_fetch_sequencer: RTL and testbench

// Instruction-fetch controller for the byte-wide instruction memory (1 KB, byte array).

---
 rtl/imem_fetch_if.sv | 27 ++
 rtl/imem_fetch_sequencer.sv | 152 +++++++++++++++
 tb/tb_imem_fetch_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// Bundle between the fetch sequencer, the byte-wide instruction memory and the core.
// The sequencer takes the master side; the memory/core environment takes the slave side.
interface imem_fetch_if #(
  parameter int ADDR_W = 10
);
  logic              fetch_en;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              busy;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, mem_rdata, out_ready,
    output mem_rd_en, mem_addr, out_valid, out_instr, out_pc, busy
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, mem_rdata, out_ready,
    input  mem_rd_en, mem_addr, out_valid, out_instr, out_pc, busy
  );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// Fetches four bytes per instruction from a byte-wide memory, assembles them big-endian
// and queues the words for the core; a redirect flushes everything and reloads the PC.
module imem_fetch_sequencer #(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  imem_fetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 2) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   k_q, k_d;
  logic [31:0]                  fetch_pc_q, fetch_pc_d;
  logic                         mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
  logic                         rvld_q, rvld_d;
  logic                         rlast_q, rlast_d;
  logic [31:0]                  rpc_q, rpc_d;
  logic [23:0]                  asm_q, asm_d;
  logic [FIFO_DEPTH-1:0][31:0]  fifo_instr_q, fifo_instr_d;
  logic [FIFO_DEPTH-1:0][31:0]  fifo_pc_q, fifo_pc_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic [CW-1:0]                infl_q, infl_d;

  logic        credit, start, push_w, pop_w;
  logic [31:0] word_w;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Words already issued but not yet pushed reserve FIFO slots, so a push never finds it full.
  always_comb begin
    credit     = (count_q + infl_q) < CW'(FIFO_DEPTH);
    state_d    = state_q;
    k_d        = k_q;
    fetch_pc_d = fetch_pc_q;
    start      = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~32'd3;
      k_d        = 2'd0;
      state_d    = bus.fetch_en ? ISSUE : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.fetch_en && credit) begin
            state_d = ISSUE;
            k_d     = 2'd0;
            start   = 1'b1;
          end
        end
        ISSUE: begin
          if (k_q == 2'd3) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            k_d        = 2'd0;
            if (bus.fetch_en && credit) start = 1'b1;
            else                        state_d = IDLE;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      endcase
    end
    mem_rd_en_d = (state_d == ISSUE);
    mem_addr_d  = mem_rd_en_d ? fetch_pc_d[ADDR_W-1:0] + ADDR_W'(k_d) : mem_addr_q;
  end

  // Return path: a byte arrives one cycle after its strobe; redirect kills whatever is in flight.
  always_comb begin
    rvld_d  = mem_rd_en_q & ~bus.redirect_valid;
    rlast_d = (k_q == 2'd3);
    rpc_d   = fetch_pc_q;
    asm_d   = rvld_q ? {asm_q[15:0], bus.mem_rdata} : asm_q;
    word_w  = {asm_q, bus.mem_rdata};
    push_w  = rvld_q & rlast_q & ~bus.redirect_valid;
    pop_w   = bus.out_valid & bus.out_ready;
  end

  always_comb begin
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    if (bus.redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      infl_d   = CW'(bus.fetch_en);
    end else begin
      if (push_w) begin
        fifo_instr_d[wr_ptr_q] = word_w;
        fifo_pc_d[wr_ptr_q]    = rpc_q;
        wr_ptr_d               = ptr_inc(wr_ptr_q);
      end
      if (pop_w) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_w) - CW'(pop_w);
      infl_d  = infl_q + CW'(start) - CW'(push_w);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      fetch_pc_q   <= RESET_PC & ~32'd3;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      rvld_q       <= 1'b0;
      rlast_q      <= 1'b0;
      rpc_q        <= '0;
      asm_q        <= '0;
      fifo_instr_q <= '0;
      fifo_pc_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      infl_q       <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      fetch_pc_q   <= fetch_pc_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      rvld_q       <= rvld_d;
      rlast_q      <= rlast_d;
      rpc_q        <= rpc_d;
      asm_q        <= asm_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      infl_q       <= infl_d;
    end
  end

  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = (count_q != '0) & ~bus.redirect_valid;
  assign bus.out_instr = fifo_instr_q[rd_ptr_q];
  assign bus.out_pc    = fifo_pc_q[rd_ptr_q];
  assign bus.busy      = (state_q == ISSUE) | rvld_q;
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench: stimulus pushes hand-computed {pc, instr} expectations, monitors pop on transfer.
module tb_imem_fetch_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_fetch_if #(.ADDR_W(10)) bus ();
  imem_fetch_if #(.ADDR_W(10)) bus2 ();

  imem_fetch_sequencer #(.ADDR_W(10), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  imem_fetch_sequencer #(.ADDR_W(10), .RESET_PC(32'h3FC), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  logic [7:0] mem [1024];
  always @(posedge clk) begin
    if (bus.mem_rd_en)  bus.mem_rdata  <= mem[bus.mem_addr];
    if (bus2.mem_rd_en) bus2.mem_rdata <= mem[bus2.mem_addr];
  end

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic exp1(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc; e.instr = instr;
    q1.push_back(e);
  endtask

  task automatic exp2(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc; e.instr = instr;
    q2.push_back(e);
  endtask

  // Monitors: sample a little after negedge so negedge-driven redirects are seen
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL sb1_unexpected: got pc=%h want none", bus.out_pc);
      end else begin
        e1 = q1.pop_front();
        chk("sb1_pc", bus.out_pc, e1.pc);
        chk("sb1_instr", bus.out_instr, e1.instr);
      end
    end
    if (rst_n && bus2.out_valid && bus2.out_ready) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL sb2_unexpected: got pc=%h want none", bus2.out_pc);
      end else begin
        e2 = q2.pop_front();
        chk("sb2_pc", bus2.out_pc, e2.pc);
        chk("sb2_instr", bus2.out_instr, e2.instr);
      end
    end
    if (rst_n && dut.push_w)  chk("push_into_full",  32'(dut.count_q >= 3'd2), 32'd0);
    if (rst_n && dut2.push_w) chk("push_into_full2", 32'(dut2.count_q >= 3'd2), 32'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    bus.fetch_en = 1'b0;  bus.redirect_valid = 1'b0;  bus.redirect_pc = '0;
    bus2.fetch_en = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0;
    cyc();
    cyc();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((bus.busy || bus.out_valid || bus2.busy || bus2.out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({nm, "_timeout"}, 32'(n >= 60), 32'd0);
    chk({nm, "_sb_left"}, 32'(q1.size() + q2.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  logic [9:0] t4_addrs [5];
  int nreads;
  int n;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
    t4_addrs = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF, 10'h000};
    bus.mem_rdata = '0;  bus2.mem_rdata = '0;
    bus.out_ready = 1'b1; bus2.out_ready = 1'b1;

    // T1: reset values, first-word latency and streaming
    do_reset();
    @(negedge clk);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_addr",  bus.mem_addr, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_instr", bus.out_instr, 0);
    chk("rst_pc",    bus.out_pc, 0);
    chk("rst_busy",  bus.busy, 0);
    exp1(32'h0, 32'h13050000);
    exp1(32'h4, 32'hA1A0A3A2);
    exp1(32'h8, 32'hADACAFAE);
    cyc(); rst_n = 1'b1; bus.fetch_en = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_rd_en", bus.mem_rd_en, 1);
      chk("t1_addr", bus.mem_addr, 32'(k));
    end
    @(negedge clk); chk("t1_c4_valid", bus.out_valid, 0);
    @(negedge clk); chk("t1_c5_valid", bus.out_valid, 1); chk("t1_c5_pc", bus.out_pc, 0);
    repeat (4) @(negedge clk);
    chk("t1_c9_valid", bus.out_valid, 1); chk("t1_c9_pc", bus.out_pc, 32'h4);
    cyc(); bus.fetch_en = 1'b0;
    drain("t1");

    // T2: core stalled from reset; credit limits to two words
    do_reset();
    bus.out_ready = 1'b0;
    exp1(32'h0, 32'h13050000);
    exp1(32'h4, 32'hA1A0A3A2);
    exp1(32'h8, 32'hADACAFAE);
    cyc(); rst_n = 1'b1; bus.fetch_en = 1'b1;
    nreads = 0;
    repeat (24) begin
      @(negedge clk);
      if (bus.mem_rd_en) begin
        chk("t2_addr", bus.mem_addr, 32'(nreads));
        nreads++;
      end
      if (bus.out_valid) begin
        chk("t2_hold_pc", bus.out_pc, 0);
        chk("t2_hold_instr", bus.out_instr, 32'h13050000);
      end
    end
    chk("t2_nreads", 32'(nreads), 8);
    chk("t2_valid", bus.out_valid, 1);
    cyc(); bus.out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.mem_rd_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t2_resume_seen", bus.mem_rd_en, 1);
    chk("t2_resume_addr", bus.mem_addr, 32'h8);
    cyc(); bus.fetch_en = 1'b0;
    drain("t2");

    // T3: redirect at k=2 of word 0x10
    do_reset();
    bus.out_ready = 1'b1;
    exp1(32'h0,  32'h13050000);
    exp1(32'h4,  32'hA1A0A3A2);
    exp1(32'h8,  32'hADACAFAE);
    exp1(32'hC,  32'hA9A8ABAA);
    exp1(32'h40, 32'hE5E4E7E6);
    cyc(); rst_n = 1'b1; bus.fetch_en = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(bus.mem_rd_en && bus.mem_addr == 10'h012) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t3_reach_k2", bus.mem_addr, 32'h12);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h43;
    #1 chk("t3_valid_forced", bus.out_valid, 0);
    cyc(); bus.redirect_valid = 1'b0; bus.fetch_en = 1'b0;
    @(negedge clk);
    chk("t3_new_rd_en", bus.mem_rd_en, 1);
    chk("t3_new_addr", bus.mem_addr, 32'h40);
    drain("t3");

    // T4: RESET_PC near the top of memory, address wrap
    do_reset();
    exp2(32'h3FC, 32'h59585B5A);
    exp2(32'h400, 32'h13050000);
    cyc(); rst_n = 1'b1; bus2.fetch_en = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_addr", bus2.mem_addr, 32'(t4_addrs[k]));
    end
    cyc(); bus2.fetch_en = 1'b0;
    drain("t4");

    // T5: redirect in the same cycle as a would-be transfer
    do_reset();
    bus.out_ready = 1'b0;
    cyc(); rst_n = 1'b1; bus.fetch_en = 1'b1;
    repeat (16) @(negedge clk);
    chk("t5_full_valid", bus.out_valid, 1);
    chk("t5_full_busy", bus.busy, 0);
    bus.out_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; bus.fetch_en = 1'b0;
    #1 chk("t5_valid_forced", bus.out_valid, 0);
    cyc(); bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_flushed", bus.out_valid, 0);
    chk("t5_no_issue", bus.mem_rd_en, 0);
    chk("t5_idle", bus.busy, 0);
    exp1(32'h100, 32'hA5A4A7A6);
    cyc(); bus.fetch_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_new_rd_en", bus.mem_rd_en, 1);
    chk("t5_new_addr", bus.mem_addr, 32'h100);
    cyc(); bus.fetch_en = 1'b0;
    drain("t5");

    // T6: one-cycle reset during k=1
    do_reset();
    bus.out_ready = 1'b1;
    exp1(32'h0, 32'h13050000);
    cyc(); rst_n = 1'b1; bus.fetch_en = 1'b1;
    @(posedge clk);
    @(negedge clk); chk("t6_c0_addr", bus.mem_addr, 0);
    @(negedge clk); chk("t6_c1_addr", bus.mem_addr, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rst_rd_en", bus.mem_rd_en, 0);
    chk("t6_rst_addr",  bus.mem_addr, 0);
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_instr", bus.out_instr, 0);
    chk("t6_rst_pc",    bus.out_pc, 0);
    chk("t6_rst_busy",  bus.busy, 0);
    @(negedge clk);
    chk("t6_refetch_rd_en", bus.mem_rd_en, 1);
    chk("t6_refetch_addr", bus.mem_addr, 0);
    cyc(); bus.fetch_en = 1'b0;
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
